// File: rtl/mp_pkg.sv
// Shared constants and tag type for the multiplier scheduler.
// The tag channel field is sized for the largest supported channel count.
package mp_pkg;

  localparam int MP_OPERAND_W = 24;
  localparam int MP_PROD_W    = 28;
  localparam int MP_LATENCY   = 5;
  localparam int MP_PROD_LSB  = 19;
  localparam int MP_CH_MAX_W  = 3;

  typedef struct packed {
    logic                   valid;
    logic [MP_CH_MAX_W-1:0] ch;
  } mp_tag_t;

endpackage

// File: rtl/mp_sched_rr_arbiter.sv
// Request arbiter for mp_sched: round-robin from a pointer, or lowest-index
// fixed priority when MP_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any,
  output logic [CH_W-1:0] next_ptr
);

  int k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    next_ptr  = ptr;
    k         = 0;
`ifdef MP_SCHED_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = CH_W'(i);
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
`else
    for (int i = 0; i < NCH; i++) begin
      k = (int'(ptr) + i) % NCH;
      if (!grant_any && req[k]) begin
        grant_idx = CH_W'(k);
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
      next_ptr         = CH_W'((int'(grant_idx) + 1) % NCH);
    end
`endif
  end

endmodule

// File: rtl/mp_sched.sv
// Shares one pipelined 24x24 multiplier between NCH channels and tags each
// product with its channel. Optional fixed priority: MP_SCHED_FIXED_PRIO_EN.
module mp_sched #(
  parameter int NCH        = 4,
  parameter int CH_W       = 2,
  parameter int MP_LATENCY = mp_pkg::MP_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NCH-1:0]                        req_i,
  input  logic [NCH*mp_pkg::MP_OPERAND_W-1:0]   mpcand_i,
  input  logic [NCH*mp_pkg::MP_OPERAND_W-1:0]   mplier_i,
  output logic [NCH-1:0]                        ack_o,
  output logic [mp_pkg::MP_OPERAND_W-1:0]       mp_a_o,
  output logic [mp_pkg::MP_OPERAND_W-1:0]       mp_b_o,
  input  logic [mp_pkg::MP_PROD_W-1:0]          mp_p_i,
  output logic [mp_pkg::MP_PROD_W-1:0]          prod_o,
  output logic                                  prod_valid_o,
  output logic [CH_W-1:0]                       prod_ch_o,
  output logic                                  busy_o
);

  import mp_pkg::*;

  logic [CH_W-1:0]        ptr_q;
  logic [CH_W-1:0]        next_ptr;
  logic [NCH-1:0]         req_gated;
  logic [NCH-1:0]         grant;
  logic [CH_W-1:0]        grant_idx;
  logic                   grant_any;
  mp_tag_t                tag_pipe [MP_LATENCY+1];
  logic [MP_CH_MAX_W-1:0] out_ch;
  logic                   unused_ch_bits;

  // Requests seen during reset must never be acknowledged.
  assign req_gated = rst ? '0 : req_i;

  rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .req       (req_gated),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any),
    .next_ptr  (next_ptr)
  );

  assign ack_o = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      mp_a_o <= '0;
      mp_b_o <= '0;
      for (int i = 0; i <= MP_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      ptr_q <= next_ptr;
      if (grant_any) begin
        mp_a_o <= mpcand_i[int'(grant_idx)*MP_OPERAND_W +: MP_OPERAND_W];
        mp_b_o <= mplier_i[int'(grant_idx)*MP_OPERAND_W +: MP_OPERAND_W];
      end
      // One stage per cycle so the tag emerges with the multiplier result.
      tag_pipe[0] <= '{valid: grant_any, ch: MP_CH_MAX_W'(grant_idx)};
      for (int i = 1; i <= MP_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign out_ch         = tag_pipe[MP_LATENCY].ch;
  assign prod_ch_o      = out_ch[CH_W-1:0];
  assign unused_ch_bits = ^out_ch;
  assign prod_valid_o   = tag_pipe[MP_LATENCY].valid;
  assign prod_o         = mp_p_i;

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i <= MP_LATENCY; i++) begin
      busy_o = busy_o | tag_pipe[i].valid;
    end
  end

endmodule

// File: tb/tb_mp_sched.sv
// Self-checking bench for mp_sched: a cycle model of arbitration and result
// timing checked every cycle, plus directed vectors with literal expectations.
module tb_mp_sched;

  localparam int NCH  = 4;
  localparam int CH_W = 2;
  localparam int LAT  = 5;
  localparam int HIST = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       req_i;
  logic [NCH*24-1:0]    mpcand_i;
  logic [NCH*24-1:0]    mplier_i;
  logic [NCH-1:0]       ack_o;
  logic [23:0]          mp_a_o;
  logic [23:0]          mp_b_o;
  logic [27:0]          mp_p_i;
  logic [27:0]          prod_o;
  logic                 prod_valid_o;
  logic [CH_W-1:0]      prod_ch_o;
  logic                 busy_o;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  mp_sched #(
    .NCH        (NCH),
    .CH_W       (CH_W),
    .MP_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .mpcand_i     (mpcand_i),
    .mplier_i     (mplier_i),
    .ack_o        (ack_o),
    .mp_a_o       (mp_a_o),
    .mp_b_o       (mp_b_o),
    .mp_p_i       (mp_p_i),
    .prod_o       (prod_o),
    .prod_valid_o (prod_valid_o),
    .prod_ch_o    (prod_ch_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Product bits [46:19] of the full signed 48-bit product.
  function automatic logic [27:0] mulRef(input logic [23:0] a, input logic [23:0] b);
    logic signed [47:0] p;
    p = $signed(a) * $signed(b);
    return p[46:19];
  endfunction

  // Stand-in for the unreset 5-stage multiplier core.
  logic [27:0] mulPipe [LAT];
  always @(posedge clk) begin
    mulPipe[0] <= mulRef(mp_a_o, mp_b_o);
    for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
  end
  assign mp_p_i = mulPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Model state: grant history per cycle, pointer and last issued operands.
  bit          gValid [HIST];
  int          gCh    [HIST];
  logic [27:0] gProd  [HIST];
  int          mPtr   = 0;
  int          lastRst = 0;
  int          g;
  logic [23:0] mA = '0;
  logic [23:0] mB = '0;
  logic [NCH-1:0] expAck;
  bit          expBusy;
  int          src;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      g = -1;
      if (!rst) begin
`ifdef MP_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NCH; i++) if (g < 0 && req_i[i]) g = i;
`else
        for (int i = 0; i < NCH; i++) if (g < 0 && req_i[(mPtr + i) % NCH]) g = (mPtr + i) % NCH;
`endif
      end
      expAck = '0;
      if (g >= 0) expAck[g] = 1'b1;
      checkOutput("model_ack", 32'(ack_o), 32'(expAck));
      checkOutput("model_mp_a", 32'(mp_a_o), 32'(mA));
      checkOutput("model_mp_b", 32'(mp_b_o), 32'(mB));

      src = cyc - (LAT + 1);
      if (src >= 0 && gValid[src] && src > lastRst) begin
        checkOutput("model_prod_valid", 32'(prod_valid_o), 32'd1);
        checkOutput("model_prod_ch", 32'(prod_ch_o), 32'(gCh[src]));
        checkOutput("model_prod", 32'(prod_o), 32'(gProd[src]));
      end else begin
        checkOutput("model_prod_valid", 32'(prod_valid_o), 32'd0);
      end

      expBusy = 1'b0;
      for (int j = 1; j <= LAT + 1; j++) begin
        if (cyc - j >= 0 && gValid[cyc-j] && (cyc - j) > lastRst) expBusy = 1'b1;
      end
      checkOutput("model_busy", 32'(busy_o), 32'(expBusy));

      gValid[cyc] = (g >= 0);
      if (g >= 0) begin
        gCh[cyc]   = g;
        gProd[cyc] = mulRef(mpcand_i[g*24 +: 24], mplier_i[g*24 +: 24]);
        mA         = mpcand_i[g*24 +: 24];
        mB         = mplier_i[g*24 +: 24];
        mPtr       = (g + 1) % NCH;
      end
      if (rst) begin
        lastRst = cyc;
        mPtr    = 0;
        mA      = '0;
        mB      = '0;
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then move to mid-cycle.
  task automatic applyStimulus(input logic rstVal, input logic [NCH-1:0] reqVal);
    @(posedge clk);
    #1;
    rst   = rstVal;
    req_i = reqVal;
    @(negedge clk);
  endtask

  task automatic setOperand(input int ch, input logic [23:0] a, input logic [23:0] b);
    mpcand_i[ch*24 +: 24] = a;
    mplier_i[ch*24 +: 24] = b;
  endtask

  initial begin
    rst      = 1'b1;
    req_i    = '0;
    mpcand_i = '0;
    mplier_i = '0;
    setOperand(0, 24'h100000, 24'h100000);
    setOperand(1, 24'h000123, 24'h7FFFFF);
    setOperand(2, 24'hFFFFFF, 24'h080000);
    setOperand(3, 24'h800000, 24'h400000);

    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("reset_ack", 32'(ack_o), 32'd0);
    checkOutput("reset_mp_a", 32'(mp_a_o), 32'd0);
    checkOutput("reset_mp_b", 32'(mp_b_o), 32'd0);
    checkOutput("reset_valid", 32'(prod_valid_o), 32'd0);
    checkOutput("reset_ch", 32'(prod_ch_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);

    // Single op on ch0: 2^20 * 2^20 >> 19 = 0x200000, returned 6 cycles later.
    applyStimulus(1'b0, 4'b0001);
    checkOutput("single_ack", 32'(ack_o), 32'h1);
    for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 4'b0000);
    checkOutput("single_early_valid", 32'(prod_valid_o), 32'd0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("single_valid", 32'(prod_valid_o), 32'd1);
    checkOutput("single_ch", 32'(prod_ch_o), 32'd0);
    checkOutput("single_prod", 32'(prod_o), 32'h0200000);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("single_late_valid", 32'(prod_valid_o), 32'd0);

    // Signed op on ch2: -1 * 2^19 >> 19 = -1.
    applyStimulus(1'b0, 4'b0100);
    checkOutput("signed_ack", 32'(ack_o), 32'h4);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b0, 4'b0000);
    checkOutput("signed_valid", 32'(prod_valid_o), 32'd1);
    checkOutput("signed_ch", 32'(prod_ch_o), 32'd2);
    checkOutput("signed_prod", 32'(prod_o), 32'hFFFFFFF);

    // Grant ch3 alone so the round-robin pointer wraps to 0.
    applyStimulus(1'b0, 4'b1000);
    checkOutput("wrap_ack", 32'(ack_o), 32'h8);

    applyStimulus(1'b0, 4'b0110);
    checkOutput("contend_ack0", 32'(ack_o), 32'h2);
    applyStimulus(1'b0, 4'b0110);
`ifdef MP_SCHED_FIXED_PRIO_EN
    checkOutput("contend_ack1", 32'(ack_o), 32'h2);
`else
    checkOutput("contend_ack1", 32'(ack_o), 32'h4);
`endif
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 4'b0000);

    // Fairness: the preceding contention left the pointer at 3 (round-robin).
    applyStimulus(1'b0, 4'b1000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b1111);
`ifdef MP_SCHED_FIXED_PRIO_EN
      checkOutput("fair_ack", 32'(ack_o), 32'h1);
`else
      checkOutput("fair_ack", 32'(ack_o), 32'h1 << (i % 4));
`endif
    end
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 4'b0000);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111);
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("rst_mid_ack", 32'(ack_o), 32'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("rst_mid_valid", 32'(prod_valid_o), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
    end
    applyStimulus(1'b0, 4'b1111);
    checkOutput("rst_ptr_ack", 32'(ack_o), 32'h1);
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("idle_ack", 32'(ack_o), 32'd0);
      checkOutput("idle_valid", 32'(prod_valid_o), 32'd0);
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
